// File: rtl/synth_reg_bank.sv
// Synth voice/global register bank with staged voice updates presented over a handshake.
// Optional readback channel enabled by defining SYNTH_REG_READBACK_EN.
module synth_reg_bank #(
   parameter int NUM_VOICES = 16,
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 8,
   localparam int VW        = $clog2(NUM_VOICES)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_valid,
   output logic                         wr_ready,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [DATA_W-1:0]            wr_data,
   output logic                         wr_err,
   input  logic                         rd_valid,
   input  logic [ADDR_W-1:0]            rd_addr,
   output logic [DATA_W-1:0]            rd_data,
   output logic                         rd_resp,
   output logic                         rd_err,
   output logic [NUM_VOICES*DATA_W-1:0] carrier_o,
   output logic [NUM_VOICES*DATA_W-1:0] modulator_o,
   output logic [NUM_VOICES*DATA_W-1:0] velocity_o,
   output logic [DATA_W-1:0]            control_o,
   output logic [DATA_W-1:0]            attack_o,
   output logic [DATA_W-1:0]            decay_o,
   output logic [DATA_W-1:0]            release_o,
   output logic [DATA_W-1:0]            mod_tau_o,
   output logic                         upd_valid,
   input  logic                         upd_ready,
   output logic [VW-1:0]                upd_voice
);

   localparam logic [31:0] NV = 32'(NUM_VOICES);
   localparam logic [31:0] G  = 3 * NV;

   typedef enum logic [2:0] {K_CAR, K_MOD, K_VEL, K_GLB, K_BAD} kind_t;
   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_PRESENT} state_t;

   typedef struct packed {
      kind_t         kind;
      logic [VW-1:0] voice;
      logic [2:0]    gidx;
   } dec_t;

   function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
      logic [31:0] a;
      dec_t        d;
      a = 32'(addr);
      d = '0;
      d.kind = K_BAD;
      if (a < NV) begin
         d.kind  = K_CAR;
         d.voice = VW'(a);
      end else if (a < 2 * NV) begin
         d.kind  = K_MOD;
         d.voice = VW'(a - NV);
      end else if (a < G) begin
         d.kind  = K_VEL;
         d.voice = VW'(a - 2 * NV);
      end else if (a < G + 32'd5) begin
         d.kind = K_GLB;
         d.gidx = 3'(a - G);
      end
      return d;
   endfunction

   logic [DATA_W-1:0]     stg_car  [NUM_VOICES];
   logic [DATA_W-1:0]     stg_mod  [NUM_VOICES];
   logic [DATA_W-1:0]     stg_vel  [NUM_VOICES];
   logic [DATA_W-1:0]     live_car [NUM_VOICES];
   logic [DATA_W-1:0]     live_mod [NUM_VOICES];
   logic [DATA_W-1:0]     live_vel [NUM_VOICES];
   logic [DATA_W-1:0]     glb      [5];
   logic [NUM_VOICES-1:0] dirty;
   logic [NUM_VOICES-1:0] dirty_next;
   logic [VW-1:0]         ptr;
   logic [VW-1:0]         ptr_inc;
   state_t                state;
   dec_t                  wr_dec;
   logic                  wr_is_voice;
   logic                  wr_fire;
   logic                  hs;

   assign wr_dec      = decode(wr_addr);
   assign wr_is_voice = (wr_dec.kind == K_CAR) || (wr_dec.kind == K_MOD) || (wr_dec.kind == K_VEL);
   assign wr_fire     = wr_valid && wr_ready;
   assign hs          = upd_valid && upd_ready;
   assign upd_voice   = ptr;
   assign ptr_inc     = (ptr == VW'(NUM_VOICES - 1)) ? '0 : ptr + 1'b1;

   // The presented voice is frozen until its handshake so the copy stays atomic.
   always_comb begin
      wr_ready = 1'b1;
      if (rst)
         wr_ready = 1'b0;
      else if (upd_valid && wr_is_voice && (wr_dec.voice == upd_voice))
         wr_ready = 1'b0;
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      dirty_next = dirty;
      if (hs)
         dirty_next[ptr] = 1'b0;
      if (wr_fire && wr_is_voice)
         dirty_next[wr_dec.voice] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the register arrays are reset flops, not RAM, because every live output must read 0 in reset.
         for (int v = 0; v < NUM_VOICES; v++) begin
            stg_car[v]  <= '0;
            stg_mod[v]  <= '0;
            stg_vel[v]  <= '0;
            live_car[v] <= '0;
            live_mod[v] <= '0;
            live_vel[v] <= '0;
         end
         for (int g = 0; g < 5; g++)
            glb[g] <= '0;
         dirty  <= '0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= 1'b0;
         if (hs) begin
            live_car[ptr] <= stg_car[ptr];
            live_mod[ptr] <= stg_mod[ptr];
            live_vel[ptr] <= stg_vel[ptr];
         end
         if (wr_fire) begin
            unique case (wr_dec.kind)
               K_CAR:   stg_car[wr_dec.voice] <= wr_data;
               K_MOD:   stg_mod[wr_dec.voice] <= wr_data;
               K_VEL:   stg_vel[wr_dec.voice] <= wr_data;
               K_GLB:   glb[wr_dec.gidx]      <= wr_data;
               default: wr_err                <= 1'b1;
            endcase
         end
         dirty <= dirty_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= '0;
         upd_valid <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (|dirty)
                  state <= S_SCAN;
            end
            S_SCAN: begin
               if (dirty[ptr]) begin
                  state     <= S_PRESENT;
                  upd_valid <= 1'b1;
               end else begin
                  ptr <= ptr_inc;
               end
            end
            S_PRESENT: begin
               if (upd_ready) begin
                  upd_valid <= 1'b0;
                  ptr       <= ptr_inc;
                  state     <= (|dirty_next) ? S_SCAN : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
      assign carrier_o[v*DATA_W +: DATA_W]   = live_car[v];
      assign modulator_o[v*DATA_W +: DATA_W] = live_mod[v];
      assign velocity_o[v*DATA_W +: DATA_W]  = live_vel[v];
   end

   assign control_o = glb[0];
   assign attack_o  = glb[1];
   assign decay_o   = glb[2];
   assign release_o = glb[3];
   assign mod_tau_o = glb[4];

`ifdef SYNTH_REG_READBACK_EN
   dec_t rd_dec;
   assign rd_dec = decode(rd_addr);

   // Voice reads see staging, globals see live; a same-edge write is not yet visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
         rd_resp <= 1'b0;
         rd_err  <= 1'b0;
      end else begin
         rd_resp <= rd_valid;
         rd_err  <= 1'b0;
         if (rd_valid) begin
            unique case (rd_dec.kind)
               K_CAR:   rd_data <= stg_car[rd_dec.voice];
               K_MOD:   rd_data <= stg_mod[rd_dec.voice];
               K_VEL:   rd_data <= stg_vel[rd_dec.voice];
               K_GLB:   rd_data <= glb[rd_dec.gidx];
               default: begin
                  rd_data <= '0;
                  rd_err  <= 1'b1;
               end
            endcase
         end
      end
   end
`else
   logic unused_rd;
   assign unused_rd = ^{rd_valid, rd_addr};
   assign rd_data   = '0;
   assign rd_resp   = 1'b0;
   assign rd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_synth_reg_bank.sv
// Scoreboard bench for synth_reg_bank at default parameters (16 voices, 32-bit data).
// Read-channel expectations follow SYNTH_REG_READBACK_EN.
module tb_synth_reg_bank;

   localparam int NV = 16;
   localparam int DW = 32;
   localparam int AW = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           wr_valid = 1'b0;
   logic           wr_ready;
   logic [AW-1:0]  wr_addr = '0;
   logic [DW-1:0]  wr_data = '0;
   logic           wr_err;
   logic           rd_valid = 1'b0;
   logic [AW-1:0]  rd_addr = '0;
   logic [DW-1:0]  rd_data;
   logic           rd_resp;
   logic           rd_err;
   logic [NV*DW-1:0] carrier_o, modulator_o, velocity_o;
   logic [DW-1:0]  control_o, attack_o, decay_o, release_o, mod_tau_o;
   logic           upd_valid;
   logic           upd_ready = 1'b0;
   logic [3:0]     upd_voice;

   synth_reg_bank #(.NUM_VOICES(NV), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_err(wr_err),
      .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data), .rd_resp(rd_resp), .rd_err(rd_err),
      .carrier_o(carrier_o), .modulator_o(modulator_o), .velocity_o(velocity_o),
      .control_o(control_o), .attack_o(attack_o), .decay_o(decay_o),
      .release_o(release_o), .mod_tau_o(mod_tau_o),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_voice(upd_voice)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]    voice;
      logic [DW-1:0] car;
      logic [DW-1:0] mod;
      logic [DW-1:0] vel;
   } upd_t;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } rd_t;

   upd_t upd_q[$];
   rd_t  rd_q[$];
   int   werr_q[$];
   upd_t last;
   bit   pending_live = 1'b0;
   int   total = 0;
   int   bad = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents a handshake or pulse.
   always @(negedge clk) begin
      if (pending_live) begin
         check("live_carrier",   carrier_o[int'(last.voice)*DW +: DW],   last.car);
         check("live_modulator", modulator_o[int'(last.voice)*DW +: DW], last.mod);
         check("live_velocity",  velocity_o[int'(last.voice)*DW +: DW],  last.vel);
         pending_live = 1'b0;
      end
      if (!rst && upd_valid && upd_ready) begin
         if (upd_q.size() == 0) begin
            check("upd_spurious", {31'b0, upd_valid}, 32'd0);
         end else begin
            last = upd_q.pop_front();
            check("upd_voice", {28'b0, upd_voice}, {28'b0, last.voice});
            pending_live = 1'b1;
         end
      end
      if (!rst && rd_resp) begin
         if (rd_q.size() == 0) begin
            check("rd_resp_spurious", {31'b0, rd_resp}, 32'd0);
         end else begin
            rd_t r;
            r = rd_q.pop_front();
            check("rd_data", rd_data, r.data);
            check("rd_err", {31'b0, rd_err}, {31'b0, r.err});
         end
      end
      if (!rst && wr_err) begin
         if (werr_q.size() == 0)
            check("wr_err_spurious", {31'b0, wr_err}, 32'd0);
         else
            void'(werr_q.pop_front());
      end
   end

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge clk);
      while (!wr_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!wr_ready) check("wr_timeout", {31'b0, wr_ready}, 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic e);
`ifdef SYNTH_REG_READBACK_EN
      rd_q.push_back('{data: d, err: e});
`endif
      @(posedge clk); #1;
      rd_valid = 1'b1;
      rd_addr  = a;
      @(posedge clk); #1;
      rd_valid = 1'b0;
`ifndef SYNTH_REG_READBACK_EN
      check("rd_tied_data", rd_data, 32'd0);
      check("rd_tied_flags", {30'b0, rd_resp, rd_err}, 32'd0);
`endif
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((upd_q.size() != 0 || pending_live) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'b0, (upd_q.size() == 0 && !pending_live)}, 32'd1);
      repeat (6) @(negedge clk);
   endtask

   task automatic wait_present(input logic [3:0] v, input string name);
      int n = 0;
      @(negedge clk);
      while (!upd_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({name, "_valid"}, {31'b0, upd_valid}, 32'd1);
      check({name, "_voice"}, {28'b0, upd_voice}, {28'b0, v});
   endtask

   initial begin
      #500us;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit flag;
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      check("rst_upd_valid", {31'b0, upd_valid}, 32'd0);
      check("rst_outputs", {31'b0, (|carrier_o) | (|modulator_o) | (|velocity_o) | (|control_o) | (|mod_tau_o)}, 32'd0);
      check("rst_pulses", {29'b0, wr_err, rd_resp, rd_err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_wr_ready", {31'b0, wr_ready}, 32'd1);

      // Global write: control at G=48, visible right after the write edge, no update
      do_write(8'd48, 32'h1234);
      check("control_o", control_o, 32'h1234);
      do_write(8'd49, 32'h77);
      check("attack_o", attack_o, 32'h77);
      flag = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (upd_valid) flag = 1'b0;
      end
      check("global_no_upd", {31'b0, flag}, 32'd1);

      // Carrier 3 + velocity 3 staged, then presented once and copied together
      @(posedge clk); #1;
      upd_ready = 1'b1;
      upd_q.push_back('{voice: 4'd3, car: 32'hAA, mod: 32'h0, vel: 32'h55});
      do_write(8'd3, 32'hAA);
      do_write(8'd35, 32'h55);
      check("car3_staged_only", carrier_o[3*DW +: DW], 32'h0);
      wait_drain("drain_v3");

      // Move ptr to 14 via voice 13, then dirty 15 and 0 -> order 15, 0
      upd_q.push_back('{voice: 4'd13, car: 32'h13, mod: 32'h0, vel: 32'h0});
      do_write(8'd13, 32'h13);
      wait_drain("drain_v13");
      upd_q.push_back('{voice: 4'd15, car: 32'hF15, mod: 32'h0, vel: 32'h0});
      upd_q.push_back('{voice: 4'd0, car: 32'h0, mod: 32'hF0, vel: 32'h0});
      do_write(8'd15, 32'hF15);
      do_write(8'd16, 32'hF0);
      wait_drain("drain_wrap");

      // Voice 5 held; write to modulator 5 (addr 21) stalls until the handshake
      @(posedge clk); #1;
      upd_ready = 1'b0;
      do_write(8'd5, 32'h505);
      wait_present(4'd5, "present5");
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_addr  = 8'd21;
      wr_data  = 32'h5A5;
      flag = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (wr_ready || !upd_valid || upd_voice != 4'd5) flag = 1'b0;
      end
      check("stall_wr_ready_low", {31'b0, flag}, 32'd1);
      check("car5_not_live", carrier_o[5*DW +: DW], 32'h0);
      upd_q.push_back('{voice: 4'd5, car: 32'h505, mod: 32'h0, vel: 32'h0});
      upd_q.push_back('{voice: 4'd5, car: 32'h505, mod: 32'h5A5, vel: 32'h0});
      @(posedge clk); #1;
      upd_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wr_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("stall_release", {31'b0, wr_ready}, 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      wait_drain("drain_v5_twice");

      // Unmapped write at 53: error pulse, no register change
      werr_q.push_back(53);
      do_write(8'd53, 32'hDEAD);
      repeat (2) @(negedge clk);
      check("unmapped_control", control_o, 32'h1234);
      check("unmapped_attack", attack_o, 32'h77);
      check("unmapped_globals", decay_o | release_o | mod_tau_o, 32'h0);
      check("unmapped_car3", carrier_o[3*DW +: DW], 32'hAA);

      // Reads: unmapped, staging voice, live global
      do_read(8'd53, 32'h0, 1'b1);
      do_read(8'd3, 32'hAA, 1'b0);
      do_read(8'd48, 32'h1234, 1'b0);

      // Same-cycle read and write of decay (50) returns the old value
`ifdef SYNTH_REG_READBACK_EN
      rd_q.push_back('{data: 32'h0, err: 1'b0});
`endif
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_addr = 8'd50; wr_data = 32'h99;
      rd_valid = 1'b1; rd_addr = 8'd50;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rd_valid = 1'b0;
      check("decay_o", decay_o, 32'h99);
      do_read(8'd50, 32'h99, 1'b0);
      repeat (3) @(negedge clk);

      // Reset in the middle of a presentation
      @(posedge clk); #1;
      upd_ready = 1'b0;
      do_write(8'd9, 32'h909);
      wait_present(4'd9, "present9");
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_upd_valid", {31'b0, upd_valid}, 32'd0);
      check("async_rst_wr_ready", {31'b0, wr_ready}, 32'd0);
      check("async_rst_outputs", {31'b0, (|carrier_o) | (|control_o) | (|attack_o) | (|decay_o)}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      upd_ready = 1'b1;
      flag = 1'b1;
      repeat (40) begin
         @(negedge clk);
         if (upd_valid) flag = 1'b0;
      end
      check("post_rst_no_upd", {31'b0, flag}, 32'd1);
      upd_q.push_back('{voice: 4'd2, car: 32'h22, mod: 32'h0, vel: 32'h0});
      do_write(8'd2, 32'h22);
      wait_drain("drain_post_rst");
      check("post_rst_car9", carrier_o[9*DW +: DW], 32'h0);

      check("upd_q_left", upd_q.size(), 32'd0);
      check("rd_q_left", rd_q.size(), 32'd0);
      check("werr_q_left", werr_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
